// File: rtl/mp_mem_pkg.sv
// Shared types and default sizes for the multiprocessor memory controller.
package mp_mem_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_BURST_LEN = 4;

  // Request opcodes as they appear on the bus.
  typedef enum logic [1:0] {
    OP_NOP        = 2'b00,
    OP_READ       = 2'b01,
    OP_WRITE      = 2'b10,
    OP_BURST_READ = 2'b11
  } opcode_e;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2,
    S_BURST = 2'd3
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_mem_ctrl_if.sv
// Request/response bus between the cores and the shared-memory controller.
interface mp_mem_ctrl_if #(
  parameter int ADDR_W    = mp_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W    = mp_mem_pkg::DEF_DATA_W,
  parameter int NUM_CORES = mp_mem_pkg::DEF_NUM_CORES,
  parameter int BURST_LEN = mp_mem_pkg::DEF_BURST_LEN
);
  import mp_mem_pkg::*;

  localparam int CORE_W = width_of(NUM_CORES);
  localparam int BID_W  = width_of(BURST_LEN);

  // Request side
  logic              req;
  logic [CORE_W-1:0] core_id;
  logic [1:0]        opcode;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;

  // Response side
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] data_out;
  logic [CORE_W-1:0] rd_core_id;
  logic [BID_W-1:0]  burst_id;
  logic              busy;

  modport master (
    output req, core_id, opcode, we, addr, data_in,
    input  gnt, rvalid, data_out, rd_core_id, burst_id, busy
  );

  modport slave (
    input  req, core_id, opcode, we, addr, data_in,
    output gnt, rvalid, data_out, rd_core_id, burst_id, busy
  );

endinterface

// File: rtl/mp_mem_array.sv
// Single-port synchronous RAM, one-cycle registered read, write-first.
module mp_mem_array
  import mp_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are never reset; a write also drives the new word onto rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mp_mem_ctrl.sv
// Shared-memory controller: one request at a time, single read/write or
// fixed-length wrapping burst read, responses tagged with core id and beat.
module mp_mem_ctrl
  import mp_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input logic         clk,
  input logic         reset,
  mp_mem_ctrl_if.slave bus
);

  localparam int CORE_W = width_of(NUM_CORES);
  localparam int BID_W  = width_of(BURST_LEN);
  localparam logic [BID_W-1:0] LAST_BEAT = BID_W'(BURST_LEN - 1);

  state_e            state_reg, state_next;
  opcode_e           op_reg;
  logic [CORE_W-1:0] core_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [BID_W-1:0]  beat_reg;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              req_ok;

  // A request whose we flag disagrees with its opcode is demoted to NOP.
  assign req_ok = (bus.we == (bus.opcode == OP_WRITE));

  mp_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; requests are only looked at while idle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.req) state_next = S_GRANT;
      end
      S_GRANT: begin
        unique case (op_reg)
          OP_READ:       state_next = S_RESP;
          OP_BURST_READ: state_next = S_BURST;
          default:       state_next = S_IDLE;
        endcase
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      S_BURST: begin
        if (beat_reg == LAST_BEAT) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs and RAM controls decoded from state and registers only.
  // In BURST the RAM is fetching one beat ahead of the beat being returned.
  always_comb begin
    bus.gnt        = 1'b0;
    bus.rvalid     = 1'b0;
    bus.busy       = (state_reg != S_IDLE);
    bus.burst_id   = '0;
    bus.rd_core_id = '0;
    bus.data_out   = hold_reg;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = addr_reg;
    unique case (state_reg)
      S_GRANT: begin
        bus.gnt = 1'b1;
        ram_en  = (op_reg != OP_NOP);
        ram_we  = (op_reg == OP_WRITE);
      end
      S_RESP: begin
        bus.rvalid     = 1'b1;
        bus.rd_core_id = core_reg;
        bus.data_out   = ram_rdata;
      end
      S_BURST: begin
        bus.rvalid     = 1'b1;
        bus.rd_core_id = core_reg;
        bus.burst_id   = beat_reg;
        bus.data_out   = ram_rdata;
        ram_en         = (beat_reg != LAST_BEAT);
        ram_addr       = addr_reg + ADDR_W'(beat_reg) + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Request latch, beat counter and the held copy of the last read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg    <= OP_NOP;
      core_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      beat_reg  <= '0;
      hold_reg  <= '0;
    end else begin
      if (state_reg == S_IDLE && bus.req) begin
        op_reg    <= req_ok ? opcode_e'(bus.opcode) : OP_NOP;
        core_reg  <= bus.core_id;
        addr_reg  <= bus.addr;
        wdata_reg <= bus.data_in;
      end
      if (state_reg == S_GRANT) begin
        beat_reg <= '0;
      end else if (state_reg == S_BURST) begin
        beat_reg <= beat_reg + BID_W'(1);
      end
      if (bus.rvalid) begin
        hold_reg <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mp_mem_ctrl.sv
// Directed, table-driven bench for mp_mem_ctrl plus multi-cycle corner cases.
module tb_mp_mem_ctrl;
  import mp_mem_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int NUM_CORES = 4;
  localparam int BURST_LEN = 4;
  localparam int K_NONE    = 0;
  localparam int K_SINGLE  = 1;
  localparam int K_BURST   = 2;
  localparam int NV        = 14;

  typedef struct {
    logic [1:0]         core;
    logic [1:0]         opcode;
    logic               we;
    logic [7:0]         addr;
    logic [31:0]        din;
    int                 kind;
    logic [3:0][31:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_data = 32'h0;
  vec_t vecs [NV];

  mp_mem_ctrl_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CORES(NUM_CORES), .BURST_LEN(BURST_LEN)
  ) bus ();

  mp_mem_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CORES(NUM_CORES), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] core, input logic [1:0] op, input logic we,
                              input logic [7:0] addr, input logic [31:0] din, input int kind,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.core = core; v.opcode = op; v.we = we; v.addr = addr; v.din = din; v.kind = kind;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic drive_req(input logic [1:0] core, input logic [1:0] op, input logic we,
                           input logic [7:0] addr, input logic [31:0] din);
    bus.req = 1'b1; bus.core_id = core; bus.opcode = op; bus.we = we;
    bus.addr = addr; bus.data_in = din;
  endtask

  // Entered at a negedge with the DUT idle; leaves at a negedge with it idle.
  task automatic run_vec(input vec_t v, input string tag);
    $display("txn %s core=%0d op=%0d we=%0d addr=0x%02h din=0x%08h", tag, v.core, v.opcode, v.we, v.addr, v.din);
    drive_req(v.core, v.opcode, v.we, v.addr, v.din);
    @(posedge clk); @(negedge clk);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'd1);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".rvalid_g"}, 32'(bus.rvalid), 32'd0);
    bus.req = 1'b0;
    if (v.kind == K_SINGLE) begin
      @(negedge clk);
      chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'd1);
      chk({tag, ".gnt_off"}, 32'(bus.gnt), 32'd0);
      chk({tag, ".data"}, bus.data_out, v.exp[0]);
      chk({tag, ".core"}, 32'(bus.rd_core_id), 32'(v.core));
      chk({tag, ".bid"}, 32'(bus.burst_id), 32'd0);
      last_data = v.exp[0];
    end else if (v.kind == K_BURST) begin
      for (int k = 0; k < BURST_LEN; k++) begin
        @(negedge clk);
        chk($sformatf("%s.b%0d.rvalid", tag, k), 32'(bus.rvalid), 32'd1);
        chk($sformatf("%s.b%0d.data", tag, k), bus.data_out, v.exp[k]);
        chk($sformatf("%s.b%0d.bid", tag, k), 32'(bus.burst_id), 32'(k));
        chk($sformatf("%s.b%0d.core", tag, k), 32'(bus.rd_core_id), 32'(v.core));
      end
      last_data = v.exp[BURST_LEN-1];
    end
    @(negedge clk);
    chk({tag, ".idle_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".idle_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".hold"}, bus.data_out, last_data);
  endtask

  initial begin
    vecs[0]  = mk(2'd1, OP_WRITE,      1'b1, 8'h10, 32'hDEADBEEF, K_NONE,   0, 0, 0, 0);
    vecs[1]  = mk(2'd2, OP_READ,       1'b0, 8'h10, 32'h0,        K_SINGLE, 32'hDEADBEEF, 0, 0, 0);
    vecs[2]  = mk(2'd0, OP_WRITE,      1'b1, 8'hFE, 32'hA0,       K_NONE,   0, 0, 0, 0);
    vecs[3]  = mk(2'd0, OP_WRITE,      1'b1, 8'hFF, 32'hA1,       K_NONE,   0, 0, 0, 0);
    vecs[4]  = mk(2'd0, OP_WRITE,      1'b1, 8'h00, 32'hA2,       K_NONE,   0, 0, 0, 0);
    vecs[5]  = mk(2'd0, OP_WRITE,      1'b1, 8'h01, 32'hA3,       K_NONE,   0, 0, 0, 0);
    vecs[6]  = mk(2'd3, OP_BURST_READ, 1'b0, 8'hFE, 32'h0,        K_BURST,  32'hA0, 32'hA1, 32'hA2, 32'hA3);
    vecs[7]  = mk(2'd0, OP_WRITE,      1'b1, 8'h20, 32'h5,        K_NONE,   0, 0, 0, 0);
    vecs[8]  = mk(2'd1, OP_WRITE,      1'b0, 8'h20, 32'hBAD,      K_NONE,   0, 0, 0, 0);
    vecs[9]  = mk(2'd2, OP_READ,       1'b0, 8'h20, 32'h0,        K_SINGLE, 32'h5, 0, 0, 0);
    vecs[10] = mk(2'd3, OP_NOP,        1'b0, 8'h20, 32'hFFFFFFFF, K_NONE,   0, 0, 0, 0);
    vecs[11] = mk(2'd0, OP_READ,       1'b1, 8'h10, 32'h1234,     K_NONE,   0, 0, 0, 0);
    vecs[12] = mk(2'd1, OP_READ,       1'b0, 8'h10, 32'h0,        K_SINGLE, 32'hDEADBEEF, 0, 0, 0);
    vecs[13] = mk(2'd3, OP_READ,       1'b0, 8'h20, 32'h0,        K_SINGLE, 32'h5, 0, 0, 0);

    bus.req = 1'b0; bus.core_id = '0; bus.opcode = '0; bus.we = 1'b0;
    bus.addr = '0; bus.data_in = '0;

    // Reset held for two edges, then ten idle cycles.
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst.gnt", 32'(bus.gnt), 32'd0);
    chk("rst.rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.data", bus.data_out, 32'd0);
    chk("rst.core", 32'(bus.rd_core_id), 32'd0);
    chk("rst.bid", 32'(bus.burst_id), 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d.gnt", i), 32'(bus.gnt), 32'd0);
      chk($sformatf("idle%0d.busy", i), 32'(bus.busy), 32'd0);
      chk($sformatf("idle%0d.rvalid", i), 32'(bus.rvalid), 32'd0);
    end

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Write request raised during the first burst beat must wait for IDLE.
    $display("txn blk burst core=1 addr=0xfe with pending write to 0xff");
    drive_req(2'd1, OP_BURST_READ, 1'b0, 8'hFE, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("blk.gnt", 32'(bus.gnt), 32'd1);
    bus.req = 1'b0;
    @(negedge clk);
    chk("blk.b0.data", bus.data_out, 32'hA0);
    chk("blk.b0.rvalid", 32'(bus.rvalid), 32'd1);
    drive_req(2'd2, OP_WRITE, 1'b1, 8'hFF, 32'h77);
    for (int k = 1; k < BURST_LEN; k++) begin
      @(negedge clk);
      chk($sformatf("blk.b%0d.gnt", k), 32'(bus.gnt), 32'd0);
      chk($sformatf("blk.b%0d.bid", k), 32'(bus.burst_id), 32'(k));
      chk($sformatf("blk.b%0d.data", k), bus.data_out, 32'hA0 + 32'(k));
    end
    last_data = 32'hA3;
    @(negedge clk);
    chk("blk.idle.busy", 32'(bus.busy), 32'd0);
    chk("blk.idle.gnt", 32'(bus.gnt), 32'd0);
    chk("blk.idle.rvalid", 32'(bus.rvalid), 32'd0);
    @(negedge clk);
    chk("blk.wr.gnt", 32'(bus.gnt), 32'd1);
    bus.req = 1'b0;
    @(negedge clk);
    chk("blk.wr.busy", 32'(bus.busy), 32'd0);
    run_vec(mk(2'd0, OP_READ, 1'b0, 8'hFF, 32'h0, K_SINGLE, 32'h77, 0, 0, 0), "blk.rd");

    // Reset during beat 1 aborts the burst.
    $display("txn rstb burst core=3 addr=0xfe reset at beat 1");
    drive_req(2'd3, OP_BURST_READ, 1'b0, 8'hFE, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("rstb.gnt", 32'(bus.gnt), 32'd1);
    bus.req = 1'b0;
    @(negedge clk);
    chk("rstb.b0.data", bus.data_out, 32'hA0);
    @(negedge clk);
    chk("rstb.b1.bid", 32'(bus.burst_id), 32'd1);
    chk("rstb.b1.data", bus.data_out, 32'h77);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstb.rvalid", 32'(bus.rvalid), 32'd0);
    chk("rstb.busy", 32'(bus.busy), 32'd0);
    chk("rstb.data", bus.data_out, 32'd0);
    chk("rstb.core", 32'(bus.rd_core_id), 32'd0);
    chk("rstb.bid", 32'(bus.burst_id), 32'd0);
    reset = 1'b0;
    last_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstb.after%0d.rvalid", i), 32'(bus.rvalid), 32'd0);
      chk($sformatf("rstb.after%0d.busy", i), 32'(bus.busy), 32'd0);
    end
    run_vec(mk(2'd1, OP_READ, 1'b0, 8'h10, 32'h0, K_SINGLE, 32'hDEADBEEF, 0, 0, 0), "rstb.rd0");
    run_vec(mk(2'd2, OP_READ, 1'b0, 8'h01, 32'h0, K_SINGLE, 32'hA3, 0, 0, 0), "rstb.rd1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp_mem_ctrl.md
Name: mp_mem_ctrl

Overview:
Shared-memory controller for the multiprocessor system. It is the design-under-test stage that consumes core requests driven over the system interface.
- Accepts one request at a time on a req/gnt handshake tagged with core_id.
- Performs single read, single write or fixed-length burst read on an internal single-port RAM.
- Returns read data with rvalid, echoing the requester's core id and the beat index.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W words.
- DATA_W, 32, data word width.
- NUM_CORES, 4, number of cores; CORE_W = $clog2(NUM_CORES) (derived).
- BURST_LEN, 4, beats per burst read; power of 2, >=2; BID_W = $clog2(BURST_LEN) (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid; held with fields stable until gnt seen.
- core_id  in  CORE_W  requesting core.
- opcode  in  2  00 NOP, 01 READ, 10 WRITE, 11 BURST_READ.
- we  in  1  write enable; must equal (opcode==WRITE), else request is treated as NOP.
- addr  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- gnt  out  1  one-cycle grant pulse.
- rvalid  out  1  read data valid.
- data_out  out  DATA_W  read data.
- rd_core_id  out  CORE_W  core_id of the request producing the current rvalid.
- burst_id  out  BID_W  beat index for rvalid (0 for single reads).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE; gnt, rvalid, busy, data_out, rd_core_id, burst_id all 0. RAM contents are not reset. Reset in any state aborts the operation; outputs are 0 the cycle after reset is sampled. A burst aborted mid-way emits no further beats.
- FSM states: IDLE, GRANT, RESP, BURST. All outputs are registered/decoded from state only; there is no combinational input-to-output path.
- IDLE: when req is sampled 1, latch core_id, opcode, we, addr, data_in, then go to GRANT. Otherwise stay in IDLE.
- GRANT: gnt=1 for exactly this cycle.
  - WRITE: RAM[addr] <= data_in at the end of GRANT, then -> IDLE.
  - READ: RAM read issued, then -> RESP.
  - BURST_READ: beat counter cleared, then -> BURST.
  - NOP or we/opcode mismatch: -> IDLE, no side effect.
- RESP: rvalid=1, data_out=RAM[addr], burst_id=0, rd_core_id=latched id; then -> IDLE.
- BURST: rvalid=1 on BURST_LEN consecutive cycles.
  - Beat k returns RAM[(addr+k) mod 2**ADDR_W]; the address wraps at the top of memory.
  - burst_id=k.
  - Goes to IDLE after beat BURST_LEN-1.
- Latency from the edge that samples req:
  - gnt: +1 cycle.
  - Single read rvalid: +2 cycles.
  - Burst beats: +2 .. +1+BURST_LEN.
- Throughput: a write completes every 2 cycles, a read every 3, a burst every 2+BURST_LEN.
- Requester protocol: after seeing gnt=1 the requester must deassert req or present a new request by the next edge. req asserted while busy is ignored (no gnt) and stays pending until IDLE.
- Read-after-write: a read granted in the cycle after a write's GRANT returns the new data.
- rvalid=0 outside RESP/BURST; data_out holds its last value when rvalid=0.

Decomposition:
- Package mp_mem_pkg: opcode_e enum (NOP/READ/WRITE/BURST_READ), state_e enum, default width localparams.
- Sub-module mp_mem_array: single-port synchronous RAM, 1-cycle read latency, write-first. The controller contains only the FSM, latch registers and beat counter.

Test Plan:
- Reset then idle: hold reset 2 cycles, req=0 -> all outputs 0, busy=0, no gnt for 10 cycles.
- Write/read: core 1 WRITE addr 0x10 data 0xDEADBEEF, then core 2 READ 0x10 -> gnt pulses 1 cycle each. rvalid 2 cycles after the read req is sampled, data_out=0xDEADBEEF, rd_core_id=2, burst_id=0.
- Burst wrap: write 0xA0..0xA3 to addrs 0xFE,0xFF,0x00,0x01, then core 3 BURST_READ 0xFE -> 4 consecutive rvalid beats, data 0xA0,0xA1,0xA2,0xA3, burst_id 0..3, busy low the cycle after beat 3.
- Busy blocking: issue BURST_READ, then assert a WRITE req in the first beat cycle -> no gnt until IDLE. The write is then granted; the memory word it targets changes only after the burst has ended.
- Illegal/NOP: opcode=WRITE with we=0 at 0x20 (preloaded with 0x5) -> gnt=1, no rvalid, a later read of 0x20 returns 0x5. opcode=NOP -> gnt only.
- Reset mid-burst: assert reset during beat 1 of a burst -> rvalid=0 from the next cycle, state IDLE. A following READ of a previously written address returns the retained data.
